// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI slave running on the system clock: oversamples sck/ss/mosi,
// shifts WIDTH-bit frames in both directions and buffers one transmit word.
`timescale 1ns/1ps

module spi_slave_xcvr #(
  parameter int unsigned      WIDTH     = 8,
  parameter bit               LSB_FIRST = 1'b1,
  parameter bit               CPHA      = 1'b0,
  parameter logic [WIDTH-1:0] FILL      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sckSync_q, ssSync_q;
  logic [1:0]       mosiSync_q;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             bufFull_q, bufFull_d;
  logic [WIDTH-1:0] txShift_q, txShift_d;
  logic [WIDTH-1:0] rxShift_q, rxShift_d;
  logic [WIDTH-1:0] rxData_q, rxData_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             rxValid_q, rxValid_d;
  logic             underrun_q, underrun_d;
  logic             frameErr_q, frameErr_d;

  logic             sckRise, sckFall, ssFall, ssRise, mosiSync;
  logic             sampleEdge, driveEdge;
  logic             accept, transfer;
  logic [WIDTH-1:0] nextWord, rxNext;

  function automatic logic headBit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] w, input logic b);
    return LSB_FIRST ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
  endfunction

  // Edges are judged between the second and third sync stages, giving a fixed
  // three-clock latency from pin to action for sck, ss and mosi alike.
  assign sckRise    = sckSync_q[1] & ~sckSync_q[2];
  assign sckFall    = ~sckSync_q[1] & sckSync_q[2];
  assign ssFall     = ~ssSync_q[1] & ssSync_q[2];
  assign ssRise     = ssSync_q[1] & ~ssSync_q[2];
  assign mosiSync   = mosiSync_q[1];
  assign sampleEdge = CPHA ? sckFall : sckRise;
  assign driveEdge  = CPHA ? sckRise : sckFall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sckSync_q  <= 3'b000;
      ssSync_q   <= 3'b111;
      mosiSync_q <= 2'b00;
      buf_q      <= '0;
      bufFull_q  <= 1'b0;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rxValid_q  <= 1'b0;
      underrun_q <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sckSync_q  <= {sckSync_q[1:0], sck};
      ssSync_q   <= {ssSync_q[1:0], ss};
      mosiSync_q <= {mosiSync_q[0], mosi};
      buf_q      <= buf_d;
      bufFull_q  <= bufFull_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rxValid_q  <= rxValid_d;
      underrun_q <= underrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssFall) state_d = SHIFT;
      SHIFT:   if (ssRise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nextWord   = bufFull_q ? buf_q : FILL;
    rxNext     = shiftIn(rxShift_q, mosiSync);
    transfer   = 1'b0;
    miso_d     = miso_q;
    txShift_d  = txShift_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    cnt_d      = cnt_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ssFall) begin
          transfer = 1'b1;
          cnt_d    = '0;
          if (CPHA) begin
            txShift_d = nextWord;
          end else begin
            miso_d    = headBit(nextWord);
            txShift_d = advance(nextWord);
          end
        end
      end
      SHIFT: begin
        if (ssRise) begin
          // A partial frame is dropped: rx_data keeps its old word.
          miso_d     = 1'b0;
          cnt_d      = '0;
          frameErr_d = (cnt_q != '0);
        end else begin
          if (driveEdge) begin
            miso_d    = headBit(txShift_q);
            txShift_d = advance(txShift_q);
          end
          if (sampleEdge) begin
            rxShift_d = rxNext;
            if (cnt_q == LAST) begin
              rxData_d  = rxNext;
              rxValid_d = 1'b1;
              cnt_d     = '0;
              transfer  = 1'b1;
              txShift_d = nextWord;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: miso_d = 1'b0;
    endcase
    // A word written while the buffer drains lands in the buffer, never in the shifter.
    accept     = tx_valid & ~bufFull_q;
    underrun_d = transfer & ~bufFull_q;
    bufFull_d  = (bufFull_q & ~transfer) | accept;
    buf_d      = accept ? tx_data : buf_q;
  end

  assign miso        = miso_q;
  assign tx_ready    = ~bufFull_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign busy        = (state_q == SHIFT);
  assign tx_underrun = underrun_q;
  assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Drives two transceiver instances (8-bit mode 0 LSB-first, 16-bit CPHA=1
// MSB-first) as an SPI master and compares against a word-level model.
`timescale 1ns/1ps

module tb_spi_slave_xcvr;

  localparam logic [15:0] FILL1 = 16'hC3A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sckM = 1'b0, ssM = 1'b1, mosiM = 1'b0;
  int   activeSel = 0;

  logic        sck0, ss0, mosi0, miso0, txValid0, txReady0, rxValid0, busy0, und0, fe0;
  logic [7:0]  txData0, rxData0;
  logic        sck1, ss1, mosi1, miso1, txValid1, txReady1, rxValid1, busy1, und1, fe1;
  logic [15:0] txData1, rxData1;

  assign sck0  = (activeSel == 0) ? sckM : 1'b0;
  assign ss0   = (activeSel == 0) ? ssM : 1'b1;
  assign mosi0 = mosiM;
  assign sck1  = (activeSel == 1) ? sckM : 1'b0;
  assign ss1   = (activeSel == 1) ? ssM : 1'b1;
  assign mosi1 = mosiM;

  spi_slave_xcvr #(.WIDTH(8), .LSB_FIRST(1'b1), .CPHA(1'b0), .FILL(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso0),
    .tx_data(txData0), .tx_valid(txValid0), .tx_ready(txReady0),
    .rx_data(rxData0), .rx_valid(rxValid0), .busy(busy0),
    .tx_underrun(und0), .frame_err(fe0));

  spi_slave_xcvr #(.WIDTH(16), .LSB_FIRST(1'b0), .CPHA(1'b1), .FILL(FILL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1),
    .tx_data(txData1), .tx_valid(txValid1), .tx_ready(txReady1),
    .rx_data(rxData1), .rx_valid(rxValid1), .busy(busy1),
    .tx_underrun(und1), .frame_err(fe1));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int          undCnt[2], rxCnt[2], feCnt[2], busyGaps[2];
  bit          expectBusy[2];
  int          mBufFull[2], expUnd[2], expRx[2], expFe[2];
  logic [31:0] mBuf[2], expRxData[2];

  // Pulse counters sample on the falling clock edge, mid-way between DUT updates.
  always @(negedge clk) begin
    if (und0) undCnt[0]++;
    if (und1) undCnt[1]++;
    if (rxValid0) rxCnt[0]++;
    if (rxValid1) rxCnt[1]++;
    if (fe0) feCnt[0]++;
    if (fe1) feCnt[1]++;
    if (expectBusy[0] && !busy0) busyGaps[0]++;
    if (expectBusy[1] && !busy1) busyGaps[1]++;
  end

  function automatic logic misoOf(input int s);
    return (s == 1) ? miso1 : miso0;
  endfunction

  function automatic logic txReadyOf(input int s);
    return (s == 1) ? txReady1 : txReady0;
  endfunction

  function automatic logic busyOf(input int s);
    return (s == 1) ? busy1 : busy0;
  endfunction

  function automatic logic [31:0] rxDataOf(input int s);
    return (s == 1) ? {16'h0, rxData1} : {24'h0, rxData0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCounters(input int s);
    checkOutput($sformatf("underrunCount%0d", s), 32'(undCnt[s]), 32'(expUnd[s]));
    checkOutput($sformatf("rxValidCount%0d", s), 32'(rxCnt[s]), 32'(expRx[s]));
    checkOutput($sformatf("rxData%0d", s), rxDataOf(s), expRxData[s]);
    checkOutput($sformatf("frameErrCount%0d", s), 32'(feCnt[s]), 32'(expFe[s]));
    checkOutput($sformatf("busyGaps%0d", s), 32'(busyGaps[s]), 32'd0);
  endtask

  task automatic pushWord(input int s, input logic [31:0] d);
    int n = 0;
    while (txReadyOf(s) !== 1'b1 && n < 20) begin
      #10;
      n++;
    end
    checkOutput("pushReadyWait", 32'(n < 20), 32'd1);
    if (s == 1) begin
      txData1 = d[15:0];
      txValid1 = 1'b1;
    end else begin
      txData0 = d[7:0];
      txValid0 = 1'b1;
    end
    #10;
    txValid0 = 1'b0;
    txValid1 = 1'b0;
    checkOutput("txReadyAfterPush", 32'(txReadyOf(s)), 32'd0);
    mBuf[s] = d;
    mBufFull[s] = 1;
  endtask

  // One ss-low period: nBits sck cycles, optional buffer write or reset before a given bit.
  task automatic applyStimulus(input int s, input int nBits, input logic [63:0] mosiWords,
                               input int loadAt, input logic [31:0] loadWord, input int resetAt);
    int          w = (s == 1) ? 16 : 8;
    bit          lsb = (s == 0);
    bit          cpha = (s == 1);
    logic [31:0] mask = (32'h1 << w) - 32'h1;
    logic [31:0] fill = (s == 1) ? {16'h0, FILL1} : 32'h0;
    logic [31:0] txWord, obsWord, mw;
    logic        got;
    int          j, k, bitPos;
    bit          stopped = 0;
    got = 1'b0;
    activeSel = s;
    txWord = (mBufFull[s] != 0) ? mBuf[s] : fill;
    if (mBufFull[s] == 0) expUnd[s]++;
    mBufFull[s] = 0;
    ssM = 1'b0;
    #60;
    expectBusy[s] = 1'b1;
    checkOutput("txReadyAfterLoad", 32'(txReadyOf(s)), 32'(mBufFull[s] == 0));
    obsWord = 32'h0;
    for (int b = 0; b < nBits && !stopped; b++) begin
      k = b / w;
      j = b % w;
      mw = mosiWords[32*k +: 32];
      bitPos = lsb ? j : (w - 1 - j);
      if (b == resetAt) begin
        expectBusy[0] = 1'b0;
        expectBusy[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetMiso", 32'(miso0), 32'd0);
        checkOutput("midResetBusy", 32'(busy0), 32'd0);
        checkOutput("midResetTxReady", 32'(txReady0), 32'd1);
        checkOutput("midResetRxData", {24'h0, rxData0}, 32'd0);
        checkOutput("midResetFlags", {29'h0, rxValid0, und0, fe0}, 32'd0);
        #9;
        ssM = 1'b1;
        sckM = 1'b0;
        #50;
        rst_n = 1'b1;
        #40;
        mBufFull[0] = 0;
        mBufFull[1] = 0;
        expRxData[0] = 32'h0;
        expRxData[1] = 32'h0;
        stopped = 1;
      end else begin
        if (b == loadAt) pushWord(s, loadWord);
        mosiM = mw[bitPos];
        #30 sckM = 1'b1;
        if (!cpha) got = misoOf(s);
        #50 sckM = 1'b0;
        if (cpha) got = misoOf(s);
        #20;
        obsWord[bitPos] = got;
        if (j == w - 1) begin
          checkOutput($sformatf("misoWord%0d_dut%0d", k, s), obsWord, txWord & mask);
          obsWord = 32'h0;
          expRx[s]++;
          expRxData[s] = mw & mask;
          txWord = (mBufFull[s] != 0) ? mBuf[s] : fill;
          if (mBufFull[s] == 0) expUnd[s]++;
          mBufFull[s] = 0;
        end
      end
    end
    if (!stopped) begin
      #60;
      expectBusy[s] = 1'b0;
      ssM = 1'b1;
      if (nBits % w != 0) expFe[s]++;
      #100;
      checkOutput("busyAfterSsRise", 32'(busyOf(s)), 32'd0);
      checkOutput("misoAfterSsRise", 32'(misoOf(s)), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sel, w, mode;
    logic [31:0] mask;
    logic [63:0] mw;
    txData0 = '0; txValid0 = 1'b0;
    txData1 = '0; txValid1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mBufFull[i] = 0; mBuf[i] = 32'h0; expUnd[i] = 0; expRx[i] = 0;
      expFe[i] = 0; expRxData[i] = 32'h0; expectBusy[i] = 1'b0;
    end

    rst_n = 1'b0;
    #20;
    checkOutput("rstMiso0", 32'(miso0), 32'd0);
    checkOutput("rstTxReady0", 32'(txReady0), 32'd1);
    checkOutput("rstRxData0", {24'h0, rxData0}, 32'd0);
    checkOutput("rstRxValid0", 32'(rxValid0), 32'd0);
    checkOutput("rstBusy0", 32'(busy0), 32'd0);
    checkOutput("rstUnderrun0", 32'(und0), 32'd0);
    checkOutput("rstFrameErr0", 32'(fe0), 32'd0);
    checkOutput("rstTxReady1", 32'(txReady1), 32'd1);
    checkOutput("rstBusy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    #20;

    pushWord(0, 32'h55);
    applyStimulus(0, 8, 64'hA3, -1, 32'h0, -1);
    checkCounters(0);

    pushWord(0, 32'hAA);
    txData0 = 8'h99;
    txValid0 = 1'b1;
    #10;
    txValid0 = 1'b0;
    checkOutput("ignoredWriteReady", 32'(txReady0), 32'd0);
    applyStimulus(0, 16, {32'h5C, 32'hB2}, 3, 32'h37, -1);
    checkCounters(0);

    applyStimulus(0, 8, 64'h6D, -1, 32'h0, -1);
    checkCounters(0);

    pushWord(0, 32'hF0);
    applyStimulus(0, 5, 64'h1F, -1, 32'h0, -1);
    checkCounters(0);

    pushWord(1, 32'hBEEF);
    applyStimulus(1, 16, 64'h1234, -1, 32'h0, -1);
    checkCounters(1);

    applyStimulus(0, 8, 64'hC5, 1, 32'h3C, 3);
    checkCounters(0);
    pushWord(0, 32'h9D);
    applyStimulus(0, 8, 64'h4B, -1, 32'h0, -1);
    checkCounters(0);
    checkCounters(1);

    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 1));
      w = (sel == 1) ? 16 : 8;
      mask = (32'h1 << w) - 32'h1;
      mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && mBufFull[sel] == 0) pushWord(sel, $urandom & mask);
      mw = {$urandom, $urandom};
      case (mode)
        0:       applyStimulus(sel, w, mw, -1, 32'h0, -1);
        1:       applyStimulus(sel, 2 * w, mw, 2, $urandom & mask, -1);
        default: applyStimulus(sel, int'($urandom_range(1, w - 1)), mw, -1, 32'h0, -1);
      endcase
      checkCounters(sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
